rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, a one-cycle request to begin a program load.
REQ-004 SHALL have port byte_in, input, 8, the incoming program stream byte.
REQ-005 SHALL have port byte_valid, input, 1, which marks byte_in as valid this cycle.
REQ-006 SHALL have port byte_ready, output, 1, high when the loader accepts a byte this cycle.
REQ-007 SHALL have port rom_in, output, 16, the assembled word to the ROM data input.
REQ-008 SHALL have port rom_address, output, 16, the ROM write address.
REQ-009 SHALL have port rom_load, output, 1, the ROM write enable, one cycle per word.
REQ-010 SHALL have port busy, output, 1, high from start acceptance until DONE, for holding the CPU in reset.
REQ-011 SHALL have port done, output, 1, high while in DONE.
REQ-012 SHALL have port error, output, 1, the checksum mismatch flag, meaningful only in DONE.

Function
REQ-013 SHALL implement states IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHECK and DONE.
REQ-014 SHALL define a byte transfer as byte_valid and byte_ready both high on a rising edge; byte_valid SHALL be ignored at all other times.
REQ-015 SHALL assert byte_ready only in CNT_HI, CNT_LO, DATA_HI, DATA_LO and CHECK.
REQ-016 SHALL use the stream format: count high byte, count low byte, then count words each sent high byte first, then (if configured) one checksum byte.
REQ-017 SHALL make these transitions: IDLE or DONE on start goes to CNT_HI, clears rom_address, error and the checksum accumulator; start in any other state is ignored.
REQ-018 SHALL make these transitions: CNT_HI on transfer goes to CNT_LO; CNT_LO on transfer goes to DATA_HI, or, if the 16-bit count is 0, to CHECK (when configured) else DONE.
REQ-019 SHALL make these transitions: DATA_HI on transfer latches rom_in[15:8] and goes to DATA_LO; DATA_LO on transfer latches rom_in[7:0] and goes to WRITE.
REQ-020 SHALL, in WRITE, assert rom_load for exactly one cycle with rom_in and rom_address stable, because the ROM samples on the falling edge mid-cycle.
REQ-021 SHALL, on leaving WRITE, increment rom_address and decrement the remaining count, then go to DATA_HI if words remain, else to CHECK (when configured) or DONE.
REQ-022 SHALL NOT wrap rom_address: the maximum count is 65535 words, so the last address is 0xFFFE.
REQ-023 SHALL hold rom_in and rom_address stable outside WRITE, and change rom_load only on rising edges.
REQ-024 SHALL hold busy high in every state except IDLE and DONE, and hold done high only in DONE.

Reset
REQ-025 SHALL, on reset assertion at any time including mid-load, immediately force state to IDLE and rom_in, rom_address, the count, the checksum, rom_load, byte_ready, busy, done and error to 0.
REQ-026 SHALL discard a load aborted by reset; words already written remain in ROM.

Configuration
REQ-027 SHALL, with ROM_LOADER_CHECKSUM_EN defined, XOR every data byte (not the count bytes) into an 8-bit accumulator, go through CHECK to accept one checksum byte, and set error if it differs from the accumulator before entering DONE.
REQ-028 SHALL, without ROM_LOADER_CHECKSUM_EN, omit CHECK and the accumulator, go directly to DONE, and tie error to 0.

Verification
REQ-029 SHALL verify: start, then stream 00 02 12 34 AB CD -> rom_load pulses twice with (addr 0000, data 1234) and (0001, ABCD), then done=1, busy=0.
REQ-030 SHALL verify: start, then count 00 00 -> no rom_load, done after CNT_LO (or after checksum byte 00 with the macro defined, error=0).
REQ-031 SHALL verify (macro defined): stream 00 01 12 34 then 26 -> error=0; then the same stream with FF -> error=1.
REQ-032 SHALL verify: byte_valid held high continuously during WRITE -> the byte is not consumed in WRITE and is taken in the next DATA_HI.
REQ-033 SHALL verify: reset asserted after the first data byte -> all outputs 0 asynchronously, and a new start reloads from address 0000.
REQ-034 SHALL verify: start pulsed mid-load -> ignored, and the load completes normally.

Source files
------------

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader
// Purpose  : Receives a length-prefixed byte stream and writes it into a
//            16-bit ROM one word per pulse. The optional trailing XOR
//            checksum is enabled by defining ROM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rom_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] rom_in,
    output logic [15:0] rom_address,
    output logic        rom_load,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CNT_HI  = 3'd1,
        CNT_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        WRITE   = 3'd5,
        CHECK   = 3'd6,
        DONE    = 3'd7
    } state_t;

`ifdef ROM_LOADER_CHECKSUM_EN
    localparam state_t c_tail = CHECK;
`else
    localparam state_t c_tail = DONE;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_count;
    logic        w_xfer;
    logic        w_cnt_zero;

    assign w_xfer     = byte_valid & byte_ready;
    assign w_cnt_zero = (r_count[15:8] == 8'd0) && (byte_in == 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are pure state decodes, so they only move on clock edges or reset.
    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        rom_load   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = CNT_HI;
            end
            CNT_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) w_next = CNT_LO;
            end
            CNT_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) w_next = w_cnt_zero ? c_tail : DATA_HI;
            end
            DATA_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) w_next = DATA_LO;
            end
            DATA_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) w_next = WRITE;
            end
            WRITE: begin
                rom_load = 1'b1;
                busy     = 1'b1;
                w_next   = (r_count == 16'd1) ? c_tail : DATA_HI;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) w_next = DONE;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) w_next = CNT_HI;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_in      <= 16'd0;
            rom_address <= 16'd0;
            r_count     <= 16'd0;
        end else begin
            case (r_state)
                IDLE, DONE: if (start) rom_address <= 16'd0;
                CNT_HI:     if (w_xfer) r_count[15:8] <= byte_in;
                CNT_LO:     if (w_xfer) r_count[7:0]  <= byte_in;
                DATA_HI:    if (w_xfer) rom_in[15:8]  <= byte_in;
                DATA_LO:    if (w_xfer) rom_in[7:0]   <= byte_in;
                WRITE: begin
                    // Count never exceeds 65535, so the address stops at 0xFFFF.
                    rom_address <= rom_address + 16'd1;
                    r_count     <= r_count - 16'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum  <= 8'd0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_csum  <= 8'd0;
                        r_error <= 1'b0;
                    end
                end
                DATA_HI, DATA_LO: if (w_xfer) r_csum <= r_csum ^ byte_in;
                CHECK:            if (w_xfer) r_error <= (byte_in != r_csum);
                default: ;
            endcase
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_loader
// Purpose  : Directed stream loads checked against a word-list model of the
//            ROM contents, plus literal expectations for key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        start      = 1'b0;
    logic [7:0]  byte_in    = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [15:0] rom_in;
    logic [15:0] rom_address;
    logic        rom_load;
    logic        busy;
    logic        done;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wlog[$];
    logic [7:0]  stream[$];
    logic        exp_err   = 1'b0;
    logic        prev_load = 1'b0;

    rom_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .rom_in     (rom_in),
        .rom_address(rom_address),
        .rom_load   (rom_load),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Every ROM write must match the next word the model predicts.
    always @(negedge clk) begin
        if (!reset) begin
            check("busy_done_exclusive", 32'(busy & done), 32'd0);
`ifdef ROM_LOADER_CHECKSUM_EN
            if (busy) check("error_while_busy", 32'(error), 32'd0);
`else
            check("error_tied_low", 32'(error), 32'd0);
`endif
            if (rom_load) begin
                check("ready_low_in_write", 32'(byte_ready), 32'd0);
                check("load_single_cycle", 32'(prev_load), 32'd0);
                wlog.push_back({rom_address, rom_in});
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h expected none", {rom_address, rom_in});
                end else begin
                    check("write_addr_data", {rom_address, rom_in}, exp_q.pop_front());
                end
            end
            prev_load = rom_load;
        end else begin
            prev_load = 1'b0;
        end
    end

    // Model: count header, then (address, word) pairs from 0, then XOR checksum.
    task automatic build_model();
        int         cnt;
        logic [7:0] x;
        exp_q.delete();
        wlog.delete();
        cnt = int'({stream[0], stream[1]});
        x   = 8'd0;
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back({16'(i), stream[2 + 2 * i], stream[3 + 2 * i]});
            x = x ^ stream[2 + 2 * i] ^ stream[3 + 2 * i];
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        exp_err = (stream[2 + 2 * cnt] != x);
`else
        exp_err = 1'b0;
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit hold);
        int n = 0;
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: got 0 expected 1 for byte %0h", b);
        end
        @(posedge clk);
        #1;
        if (!hold) byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_error"}, 32'(error), 32'(exp_err));
        check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_load(input string name, input bit hold, input bit mid_start);
        build_model();
        pulse_start();
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], hold);
            if (mid_start && i == 3) pulse_start();
        end
        byte_valid = 1'b0;
        wait_done(name);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rom_in"}, 32'(rom_in), 32'd0);
        check({name, "_rom_address"}, 32'(rom_address), 32'd0);
        check({name, "_rom_load"}, 32'(rom_load), 32'd0);
        check({name, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Two-word load.
`ifdef ROM_LOADER_CHECKSUM_EN
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
`else
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`endif
        run_load("two_words", 1'b0, 1'b0);
        check("two_words_count", 32'(wlog.size()), 32'd2);
        check("two_words_w0", wlog[0], 32'h0000_1234);
        check("two_words_w1", wlog[1], 32'h0001_ABCD);
        check("two_words_done_lit", 32'(done), 32'd1);

        // Zero-length load.
`ifdef ROM_LOADER_CHECKSUM_EN
        stream = '{8'h00, 8'h00, 8'h00};
`else
        stream = '{8'h00, 8'h00};
`endif
        run_load("zero_count", 1'b0, 1'b0);
        check("zero_count_writes", 32'(wlog.size()), 32'd0);

`ifdef ROM_LOADER_CHECKSUM_EN
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        run_load("csum_good", 1'b0, 1'b0);
        check("csum_good_lit", 32'(error), 32'd0);
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'hFF};
        run_load("csum_bad", 1'b0, 1'b0);
        check("csum_bad_lit", 32'(error), 32'd1);
`endif

        // byte_valid held high through WRITE.
`ifdef ROM_LOADER_CHECKSUM_EN
        stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
`else
        stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
        run_load("valid_held", 1'b1, 1'b0);
        check("valid_held_w1", wlog[1], 32'h0001_3344);

        // Start pulsed mid-load is ignored.
`ifdef ROM_LOADER_CHECKSUM_EN
        stream = '{8'h00, 8'h02, 8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h00};
`else
        stream = '{8'h00, 8'h02, 8'hA5, 8'h5A, 8'h0F, 8'hF0};
`endif
        run_load("mid_start", 1'b0, 1'b1);
        check("mid_start_w1", wlog[1], 32'h0001_0FF0);

        // Asynchronous reset after the first data byte, then a fresh load.
        exp_q.delete();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_rom_in_hi", 32'(rom_in[15:8]), 32'h12);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
        stream = '{8'h00, 8'h01, 8'h56, 8'h78, 8'h2E};
`else
        stream = '{8'h00, 8'h01, 8'h56, 8'h78};
`endif
        run_load("after_reset", 1'b0, 1'b0);
        check("after_reset_w0", wlog[0], 32'h0000_5678);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
